// File: rtl/sdckgen_wide.sv
// SD/SDIO card-clock generator: NCK sub-samples per i_clk, config applied only at period ends.
// Define SDCKGEN_CKCOUNT_EN to build the saturating rising-edge counter on o_ckcount.
module sdckgen_wide #(
  parameter int unsigned NCK   = 8,
  parameter int unsigned LGDIV = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [LGDIV-1:0] i_cfg_ckspd,
  input  logic             i_cfg_clk90,
  input  logic             i_cfg_shutdown,
  output logic             o_ckstb,
  output logic             o_hlfck,
  output logic [NCK-1:0]   o_ckwide,
  output logic             o_stopped,
  output logic [LGDIV-1:0] o_ckspd,
  output logic [31:0]      o_ckcount
);
  localparam int unsigned HALF = NCK / 2;

  // Levels of a period no longer than one word, repeated across the word (MSB earliest).
  function automatic logic [NCK-1:0] mk_pat(input int unsigned per, input logic shift);
    logic [NCK-1:0] pat;
    int unsigned    ph;
    pat = '0;
    for (int unsigned i = 0; i < NCK; i++) begin
      ph     = (NCK - 1 - i) % per;
      pat[i] = shift ? ((ph >= per / 4) && (ph < 3 * per / 4)) : (ph < per / 2);
    end
    return pat;
  endfunction

  localparam logic [NCK-1:0] PAT0    = mk_pat(NCK / 2, 1'b0);
  localparam logic [NCK-1:0] PAT0_90 = mk_pat(NCK / 2, 1'b1);
  localparam logic [NCK-1:0] PAT1    = mk_pat(NCK, 1'b0);
  localparam logic [NCK-1:0] PAT1_90 = mk_pat(NCK, 1'b1);

  // ST_GAP is the all-zero cycle before a (re)start or a clk90 change.
  typedef enum logic [1:0] {ST_STOPPED, ST_GAP, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [LGDIV-1:0] spd_q, spd_d, pspd_q, pspd_d, cnt_q, cnt_d;
  logic             c90_q, c90_d, pc90_q, pc90_d, phase_q, phase_d;
  logic             c90_in, last_cnt, period_end;
  logic [LGDIV-1:0] half_m1;
  logic [NCK-1:0]   ckwide_d;
  logic             ckstb_d, hlfck_d, stopped_d;
  logic [LGDIV-1:0] h_d, s_hi, s_lo;
  logic             lvl_hi, lvl_lo;

  assign o_ckspd = spd_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_STOPPED;
      spd_q     <= '0;
      c90_q     <= 1'b0;
      pspd_q    <= '0;
      pc90_q    <= 1'b0;
      phase_q   <= 1'b0;
      cnt_q     <= '0;
      o_ckwide  <= '0;
      o_ckstb   <= 1'b0;
      o_hlfck   <= 1'b0;
      o_stopped <= 1'b1;
    end else begin
      state_q   <= state_d;
      spd_q     <= spd_d;
      c90_q     <= c90_d;
      pspd_q    <= pspd_d;
      pc90_q    <= pc90_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      o_ckwide  <= ckwide_d;
      o_ckstb   <= ckstb_d;
      o_hlfck   <= hlfck_d;
      o_stopped <= stopped_d;
    end
  end

  // Period sequencing: phase_q selects high/low half, cnt_q counts cycles within the half.
  always_comb begin
    state_d    = state_q;
    spd_d      = spd_q;
    c90_d      = c90_q;
    pspd_d     = pspd_q;
    pc90_d     = pc90_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    c90_in     = i_cfg_clk90 & ~((i_cfg_ckspd == '0) && (NCK < 8));
    half_m1    = spd_q - LGDIV'(2);
    last_cnt   = (cnt_q == half_m1);
    period_end = (spd_q < LGDIV'(2)) || (phase_q && last_cnt);
    unique case (state_q)
      ST_STOPPED: begin
        pspd_d = i_cfg_ckspd;
        pc90_d = c90_in;
        if (!i_cfg_shutdown) state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_RUN;
        spd_d   = pspd_q;
        c90_d   = pc90_q;
        phase_d = 1'b0;
        cnt_d   = '0;
      end
      ST_RUN: begin
        if (period_end) begin
          if (i_cfg_shutdown) begin
            state_d = ST_STOPPED;
          end else if (c90_in != c90_q) begin
            state_d = ST_GAP;
            pspd_d  = i_cfg_ckspd;
            pc90_d  = c90_in;
          end else begin
            spd_d   = i_cfg_ckspd;
            c90_d   = c90_in;
            phase_d = 1'b0;
            cnt_d   = '0;
          end
        end else if (last_cnt) begin
          phase_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LGDIV'(1);
        end
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Word for the next cycle; a quarter shift splits each word into two half-word windows.
  always_comb begin
    ckwide_d  = '0;
    ckstb_d   = 1'b0;
    hlfck_d   = 1'b0;
    stopped_d = (state_d == ST_STOPPED);
    h_d       = spd_d - LGDIV'(1);
    s_hi      = c90_d ? (h_d >> 1) + LGDIV'(h_d[0]) : '0;
    s_lo      = c90_d ? (h_d >> 1) : '0;
    lvl_hi    = phase_d ? (cnt_d < s_hi) : (cnt_d >= s_hi);
    lvl_lo    = phase_d ? (cnt_d < s_lo) : (cnt_d >= s_lo);
    if (state_d == ST_RUN) begin
      if (spd_d < LGDIV'(2)) begin
        if (spd_d == '0) ckwide_d = c90_d ? PAT0_90 : PAT0;
        else             ckwide_d = c90_d ? PAT1_90 : PAT1;
        ckstb_d = 1'b1;
        hlfck_d = 1'b1;
      end else begin
        ckwide_d = {{HALF{lvl_hi}}, {HALF{lvl_lo}}};
        ckstb_d  = ~phase_d && (cnt_d == '0);
        hlfck_d  = phase_d && (cnt_d == '0);
      end
    end
  end

`ifdef SDCKGEN_CKCOUNT_EN
  localparam int unsigned EW = $clog2(NCK + 1);
  logic [NCK-1:0] rise;
  logic [EW-1:0]  n_rise;
  logic [32:0]    sum;
  logic [31:0]    count_d;

  // Rising edges include the step from the previous word's last sub-sample.
  always_comb begin
    rise   = ckwide_d & ~{o_ckwide[0], ckwide_d[NCK-1:1]};
    n_rise = '0;
    for (int unsigned i = 0; i < NCK; i++) n_rise = n_rise + EW'(rise[i]);
    sum     = {1'b0, o_ckcount} + 33'(n_rise);
    count_d = sum[32] ? '1 : sum[31:0];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) o_ckcount <= '0;
    else            o_ckcount <= count_d;
  end
`else
  assign o_ckcount = '0;
`endif

endmodule

// File: tb/tb_sdckgen_wide.sv
// Randomized bench for sdckgen_wide against a sub-sample timeline model of the card clock.
module tb_sdckgen_wide;
  localparam int unsigned NCK   = 8;
  localparam int unsigned LGDIV = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [LGDIV-1:0] ckspd = '0;
  logic             clk90 = 1'b0;
  logic             sd = 1'b0;
  logic             ckstb, hlfck, stopped;
  logic [NCK-1:0]   ckwide;
  logic [LGDIV-1:0] ckspd_o;
  logic [31:0]      ckcount;

  sdckgen_wide #(.NCK(NCK), .LGDIV(LGDIV)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_cfg_ckspd(ckspd), .i_cfg_clk90(clk90),
    .i_cfg_shutdown(sd), .o_ckstb(ckstb), .o_hlfck(hlfck), .o_ckwide(ckwide),
    .o_stopped(stopped), .o_ckspd(ckspd_o), .o_ckcount(ckcount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCK-1:0]   w;
    logic             stb;
    logic             hlf;
    logic             stp;
    logic [LGDIV-1:0] spd;
  } rec_t;

  int              n_chk = 0;
  int              n_fail = 0;
  rec_t            q[$];
  rec_t            exp_r;
  bit              m_run, m_c90, m_lsb;
  logic [LGDIV-1:0] m_spd;
  longint unsigned m_cnt;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", tag, act, want, $time);
    end
  endtask

  function automatic rec_t mk(input logic [NCK-1:0] w, input logic stb, input logic hlf,
                              input logic stp, input logic [LGDIV-1:0] spd);
    rec_t r;
    r.w = w; r.stb = stb; r.hlf = hlf; r.stp = stp; r.spd = spd;
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_run = 0; m_c90 = 0; m_lsb = 0; m_spd = '0; m_cnt = 0;
    exp_r = mk('0, 0, 0, 1, '0);
  endtask

  // One full period laid out on the sub-sample timeline, cut into i_clk words.
  task automatic gen_period(input int k, input bit c90);
    int   p, ncyc, sp;
    rec_t r;
    p    = (k == 0) ? NCK / 2 : (k == 1) ? NCK : 2 * (k - 1) * NCK;
    ncyc = (k <= 1) ? 1 : 2 * (k - 1);
    for (int c = 0; c < ncyc; c++) begin
      r.w = '0;
      for (int j = 0; j < NCK; j++) begin
        sp = (c * NCK + j) % p;
        r.w[NCK-1-j] = c90 ? ((sp >= p / 4) && (sp < 3 * p / 4)) : (sp < p / 2);
      end
      r.stb = (k <= 1) ? 1'b1 : (c == 0);
      r.hlf = (k <= 1) ? 1'b1 : (c == k - 1);
      r.stp = 1'b0;
      r.spd = LGDIV'(k);
      q.push_back(r);
    end
  endtask

  task automatic model_step();
    bit c90e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_run && q.size() != 0) begin
      exp_r = q.pop_front();
    end else if (sd) begin
      m_run = 0;
      exp_r = mk('0, 0, 0, 1, m_spd);
    end else begin
      c90e = clk90 && !((ckspd == 0) && (NCK < 8));
      if (!m_run || c90e != m_c90) q.push_back(mk('0, 0, 0, 0, m_spd));
      m_run = 1;
      m_c90 = c90e;
      gen_period(int'(ckspd), c90e);
      exp_r = q.pop_front();
    end
    m_spd = exp_r.spd;
    for (int j = NCK - 1; j >= 0; j--) begin
      if (exp_r.w[j] && !m_lsb && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      m_lsb = exp_r.w[j];
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef SDCKGEN_CKCOUNT_EN
    return 32'(m_cnt);
`else
    return '0;
`endif
  endfunction

  task automatic check_outputs();
    chk("ckwide", 64'(ckwide), 64'(exp_r.w));
    chk("ckstb", 64'(ckstb), 64'(exp_r.stb));
    chk("hlfck", 64'(hlfck), 64'(exp_r.hlf));
    chk("stopped", 64'(stopped), 64'(exp_r.stp));
    chk("ckspd", 64'(ckspd_o), 64'(exp_r.spd));
    chk("ckcount", 64'(ckcount), 64'(exp_count()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance to the first high cycle of a period at speed k, then one more cycle.
  task automatic to_second_high(input logic [LGDIV-1:0] k);
    bit found;
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      found = ckstb && (ckspd_o == k);
    end
    chk("wait_ckstb", 64'(found), 64'd1);
    tick();
  endtask

  initial begin
    int          n;
    logic [31:0] want20;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_outputs();
    run(2);
    rst_n = 1'b1;

    // k=0 straight out of reset: gap cycle, then ten CC words.
    run(11);
`ifdef SDCKGEN_CKCOUNT_EN
    want20 = 32'd20;
`else
    want20 = 32'd0;
`endif
    chk("ckcount_10cyc_k0", 64'(ckcount), 64'(want20));
    chk("lit_k0", 64'(ckwide), 64'h CC);
    clk90 = 1'b1; run(6);
    chk("lit_k0_90", 64'(ckwide), 64'h66);
    ckspd = 8'd1; clk90 = 1'b0; run(6);
    chk("lit_k1", 64'(ckwide), 64'hF0);
    clk90 = 1'b1; run(6);
    chk("lit_k1_90", 64'(ckwide), 64'h3C);
    ckspd = 8'd2; clk90 = 1'b0; run(8);
    clk90 = 1'b1; run(8);
    clk90 = 1'b0; ckspd = 8'd5; run(20);

    // Speed change from 5 to 1 during the second high cycle.
    to_second_high(8'd5);
    ckspd = 8'd1; run(10);

    // Shutdown mid-high at k=5, then restart.
    ckspd = 8'd5;
    to_second_high(8'd5);
    sd = 1'b1;
    n = 0;
    while (!stopped && n < 20) begin
      tick();
      n++;
    end
    chk("stop_latency", 64'(n), 64'd7);
    chk("stop_word", 64'(ckwide), 64'h0);
    run(3);
    sd = 1'b0; tick();
    chk("restart_stopped", 64'(stopped), 64'd0);
    tick();
    chk("restart_ckstb", 64'(ckstb), 64'd1);

    // Pending shutdown withdrawn before the period end.
    to_second_high(8'd5);
    sd = 1'b1; run(2);
    sd = 1'b0; run(12);

    // Asynchronous reset mid-run.
    ckspd = 8'd3; run(7);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    chk("arst_stopped", 64'(stopped), 64'd1);
    run(2);
    rst_n = 1'b1;
    run(10);

    // Widest divider setting.
    ckspd = 8'd255; clk90 = 1'b1; run(1100);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) ckspd = 8'($urandom_range(9));
      if ($urandom_range(15) == 0) clk90 = ~clk90;
      if (!sd && $urandom_range(63) == 0) sd = 1'b1;
      else if (sd && $urandom_range(7) == 0) sd = 1'b0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sdckgen_wide.md
Name: sdckgen_wide

Overview:
Parametrised SD/SDIO card-clock generator, the next generation of the existing card-clock generator in the SDIO front end.
- Produces a multi-phase (serdes) clock word for the pad, plus launch/sample strobes for the command and data engines.
- Adds a parametrised serdes width and divider width.
- Config changes are glitch-free and only take effect at period boundaries.
- Adds a shutdown handshake with a stopped indication.

Parameters:
NCK, 8, sub-samples per i_clk in o_ckwide; power of 2, 4..32; MSB is the earliest sub-sample.
LGDIV, 8, width of the speed code and divider counter.

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_cfg_ckspd  in  LGDIV  speed code
i_cfg_clk90  in  1  shift the card clock a quarter period later
i_cfg_shutdown  in  1  stop the card clock (low) at the next period end
o_ckstb  out  1  cycle containing the nominal rising edge (data launch)
o_hlfck  out  1  cycle containing the nominal falling edge
o_ckwide  out  NCK  card-clock level per sub-sample
o_stopped  out  1  clock halted, line low
o_ckspd  out  LGDIV  speed code currently applied
o_ckcount  out  32  rising-edge counter (optional feature)

Behaviour:
- Reset (async, i_reset_n=0):
  - o_ckwide=0, o_ckstb=0, o_hlfck=0, o_stopped=1, o_ckspd=0, o_ckcount=0.
  - Internal state is STOPPED.
- All outputs are registered.
- Period P, in sub-samples, per speed code k:
  - k=0: P=NCK/2 (two card cycles per i_clk).
  - k=1: P=NCK.
  - k>=2: P=2(k-1)·NCK. High for k-1 whole cycles, then low for k-1 whole cycles.
- Each period is high first, then low.
- clk90=1 delays the waveform by P/4 sub-samples.
  - Tail bits that cross into the next i_clk are carried in an NCK-bit register.
  - For k=0 with NCK<8, clk90 is ignored (treated as 0).
- Strobes follow the nominal (unshifted) boundaries:
  - k=0 or k=1: o_ckstb=o_hlfck=1 every RUN cycle.
  - k>=2: o_ckstb=1 on the first high cycle, o_hlfck=1 on the first low cycle.
- States and transitions:
  - STOPPED: o_ckwide=0, o_stopped=1, no strobes, config sampled every cycle.
  - STOPPED->RUN when reset is released and i_cfg_shutdown=0. In RUN, o_stopped=0 on the next cycle and the first o_ckstb follows one cycle later.
  - RUN: free-running period counter.
  - At each period end (last nominal low sub-sample), config is resampled and o_ckspd updates on the same cycle the new period starts.
  - RUN->STOPPED at a period end when shutdown=1. Carry bits drain first: o_stopped rises once o_ckwide=0.
- Glitch-free config changes:
  - A change mid-period is ignored until the period end. No high or low phase is ever shorter than the smaller of the old and new half periods.
  - A clk90 change inserts one all-zero i_clk before the new waveform.
- Shutdown deasserted while a stop is pending, before the period end: no stop occurs.
- Divider counter width is LGDIV. The maximum half period is 2^LGDIV-2 cycles, with no wrap.

Optional Feature:
- SDCKGEN_CKCOUNT_EN defined:
  - o_ckcount increments by the number of rising edges in each o_ckwide word (2 per cycle at k=0).
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by reset.
- Not defined: o_ckcount is tied to 0 and no counter logic is built.

Test Plan:
- NCK=8, k=1, clk90=0 -> o_ckwide=8'hF0 every cycle, o_ckstb=o_hlfck=1. Then clk90=1 -> one 8'h00 cycle, then 8'h3C steady.
- k=0 -> o_ckwide=8'hCC steady. clk90=1 -> 8'h66 steady after one 8'h00 cycle.
- k=2 -> o_ckwide alternates FF/00, o_ckstb on FF cycles, o_hlfck on 00 cycles. clk90=1 -> alternates 0F/F0, o_ckstb on 0F cycles.
- k=5 -> 4 cycles FF, 4 cycles 00, o_ckstb period 8 cycles. Switch to k=1 during the 2nd high cycle -> remaining 2 FF + 4 00 complete, then F0; o_ckspd changes 5->1 on the first F0 cycle.
- Shutdown at k=5 mid-high -> period completes, o_stopped=1 within 7 cycles with o_ckwide=00. Deassert -> o_stopped=0 next cycle, first o_ckstb one cycle later.
- i_reset_n low mid-RUN -> all outputs zero and o_stopped=1 with no clock edge. With SDCKGEN_CKCOUNT_EN, 10 cycles at k=0 -> o_ckcount=20.
